player_ctrl: RTL

Per-player movement and bomb-placement controller, instantiated once per player directly upstream of the grid-state block. It turns debounced direction/bomb buttons into the 8-bit grid coordinate (`pN_cor`) and the 1-cycle bomb-set pulse (`pN_set`) that the grid consumes. It enforces wall/bomb collision, board edges and movement rate, and limits bomb placement against the capacity and unexploded count fed back from the grid. It freezes when the grid raises `game_over`.

---
 rtl/player_ctrl_if.sv | 33 +++
 rtl/player_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/player_ctrl_if.sv
// Bundle between one player's button/grid sources and its movement controller.
// Latency: none (wires only).
// Backpressure: none; the grid feeds back capacity and bomb counts instead.
interface player_ctrl_if;
  logic         btn_up;
  logic         btn_down;
  logic         btn_left;
  logic         btn_right;
  logic         btn_bomb;
  logic [255:0] wall_grid;
  logic [255:0] bomb_grid;
  logic [2:0]   bomb_cap;
  logic [2:0]   bomb_unexp_num;
  logic         game_over;
  logic [7:0]   cor;
  logic         set;
  logic [1:0]   facing;
  logic         moving;

  // Side that drives buttons and grid state (upstream / grid).
  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_bomb,
    output wall_grid, bomb_grid, bomb_cap, bomb_unexp_num, game_over,
    input  cor, set, facing, moving
  );

  // Controller side.
  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_bomb,
    input  wall_grid, bomb_grid, bomb_cap, bomb_unexp_num, game_over,
    output cor, set, facing, moving
  );
endinterface

// File: rtl/player_ctrl.sv
// Per-player movement/bomb controller: buttons -> grid coordinate and bomb-set pulse.
// Latency: 1 clk from button to cor/facing/set; moves spaced MOVE_COOLDOWN cycles.
// Backpressure: none; refused moves and illegal bomb edges are dropped, game_over freezes.
module player_ctrl #(
  parameter logic [7:0]  START_COR     = 8'h00,
  parameter int unsigned MOVE_COOLDOWN = 5_000_000
) (
  input logic          clk,
  input logic          rst_n,
  player_ctrl_if.slave bus
);

  localparam int CNT_W = (MOVE_COOLDOWN > 2) ? $clog2(MOVE_COOLDOWN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MOVE_COOLDOWN - 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_FROZEN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cor_q, cor_d;
  logic [1:0]       facing_q, facing_d;
  logic             set_q, set_d;
  logic             moving_q, moving_d;
  logic             bomb_prev_q, bomb_prev_d;

  logic       dir_vld;
  logic [1:0] dir_sel;
  logic [7:0] target;
  logic       in_range;
  logic       move_ok;
  logic       bomb_edge;
  logic       bomb_ok;

  // Pick one direction by priority UP > RIGHT > DOWN > LEFT and form the target cell.
  always_comb begin
    dir_vld  = 1'b1;
    dir_sel  = DIR_DOWN;
    target   = cor_q;
    in_range = 1'b0;
    if (bus.btn_up)         dir_sel = DIR_UP;
    else if (bus.btn_right) dir_sel = DIR_RIGHT;
    else if (bus.btn_down)  dir_sel = DIR_DOWN;
    else if (bus.btn_left)  dir_sel = DIR_LEFT;
    else                    dir_vld = 1'b0;
    case (dir_sel)
      DIR_UP: begin
        in_range = (cor_q[7:4] != 4'd0);
        target   = {cor_q[7:4] - 4'd1, cor_q[3:0]};
      end
      DIR_DOWN: begin
        in_range = (cor_q[7:4] != 4'd15);
        target   = {cor_q[7:4] + 4'd1, cor_q[3:0]};
      end
      DIR_LEFT: begin
        in_range = (cor_q[3:0] != 4'd0);
        target   = {cor_q[7:4], cor_q[3:0] - 4'd1};
      end
      default: begin
        in_range = (cor_q[3:0] != 4'd15);
        target   = {cor_q[7:4], cor_q[3:0] + 4'd1};
      end
    endcase
  end

  // Acceptance of a move and of a bomb edge; the bomb checks the pre-move cell.
  always_comb begin
    move_ok   = (state_q == ST_IDLE) && dir_vld && in_range && !bus.game_over &&
                !bus.wall_grid[target] && !bus.bomb_grid[target];
    bomb_edge = bus.btn_bomb && !bomb_prev_q;
    // set_q blocks a request because the grid's unexploded count lags set by a cycle.
    bomb_ok   = bomb_edge && (bus.bomb_unexp_num < bus.bomb_cap) &&
                !bus.bomb_grid[cor_q] && !set_q &&
                (state_q != ST_FROZEN) && !bus.game_over;
  end

  // Next-state and registered-output logic for the movement FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cor_d       = cor_q;
    facing_d    = facing_q;
    set_d       = bomb_ok;
    bomb_prev_d = bus.btn_bomb;
    case (state_q)
      ST_IDLE: begin
        if (bus.game_over) begin
          state_d = ST_FROZEN;
        end else begin
          if (dir_vld) facing_d = dir_sel;
          if (move_ok) begin
            cor_d = target;
            // With a one-cycle cooldown the next move is legal immediately.
            if (MOVE_COOLDOWN > 1) begin
              state_d = ST_COOLDOWN;
              cnt_d   = CNT_LOAD;
            end
          end
        end
      end
      ST_COOLDOWN: begin
        if (bus.game_over) begin
          state_d = ST_FROZEN;
        end else begin
          if (dir_vld) facing_d = dir_sel;
          // Leaving when the count reaches 0 spaces held-button moves by MOVE_COOLDOWN.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_FROZEN: begin
        state_d = ST_FROZEN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    moving_d = (state_d == ST_COOLDOWN);
  end

  // State and output registers; bomb_prev resets high so a held button is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cor_q       <= START_COR;
      facing_q    <= DIR_DOWN;
      set_q       <= 1'b0;
      moving_q    <= 1'b0;
      bomb_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cor_q       <= cor_d;
      facing_q    <= facing_d;
      set_q       <= set_d;
      moving_q    <= moving_d;
      bomb_prev_q <= bomb_prev_d;
    end
  end

  assign bus.cor    = cor_q;
  assign bus.set    = set_q;
  assign bus.facing = facing_q;
  assign bus.moving = moving_q;

endmodule
